// File: rtl/pmod_i2s_pkg.sv
// rtl/pmod_i2s_pkg.sv - shared I2S framing constants and slot helpers for pmod_in/pmod_out
package pmod_i2s_pkg;
    localparam int ADC_DATA_W      = 24;
    localparam int MCLK_PER_FS     = 256;
    localparam int SCLK_PER_FS     = 64;
    localparam int SLOTS_PER_CH    = 32;
    localparam int DATA_FIRST_SLOT = 1;
    localparam int DATA_LAST_SLOT  = DATA_FIRST_SLOT + ADC_DATA_W - 1;
    localparam int SLOT_W          = $clog2(SLOTS_PER_CH);

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } i2s_ch_e;

    // Slot index sits just above the two SCLK phase bits of the divider.
    function automatic logic [SLOT_W-1:0] slot_of(input logic [31:0] cnt, input int mclk_log2);
        return SLOT_W'(cnt >> (mclk_log2 + 2));
    endfunction

    function automatic logic is_data_slot(input logic [SLOT_W-1:0] slot);
        return (slot >= SLOT_W'(DATA_FIRST_SLOT)) && (slot <= SLOT_W'(DATA_LAST_SLOT));
    endfunction
endpackage

// File: rtl/pmod_i2s_clkgen.sv
// rtl/pmod_i2s_clkgen.sv - I2S master divider: MCLK/SCLK/LRCLK, slot index, sample and frame_end strobes
module pmod_i2s_clkgen
    import pmod_i2s_pkg::*;
#(
    parameter int CLK_PER_MCLK_LOG2 = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    output logic              mclk_o,
    output logic              sclk_o,
    output logic              lrclk_o,
    output logic [SLOT_W-1:0] slot_o,
    output i2s_ch_e           ch_o,
    output logic              sample_o,
    output logic              frame_end_o
);
    localparam int L      = CLK_PER_MCLK_LOG2;
    localparam int CW     = L + $clog2(MCLK_PER_FS);
    localparam int SCLK_B = L + $clog2(MCLK_PER_FS / SCLK_PER_FS) - 1;
    localparam int PW     = SCLK_B + 1;
    // Mid SCLK-high: leaves several clk of margin for the SDOUT synchroniser.
    localparam logic [PW-1:0] SAMPLE_PHASE = PW'(3 << L);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb cnt_d = en_i ? cnt_q + CW'(1) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign mclk_o      = cnt_q[L-1];
    assign sclk_o      = cnt_q[SCLK_B];
    assign lrclk_o     = cnt_q[CW-1];
    assign ch_o        = i2s_ch_e'(cnt_q[CW-1]);
    assign slot_o      = slot_of(32'(cnt_q), L);
    assign sample_o    = en_i && (cnt_q[PW-1:0] == SAMPLE_PHASE);
    assign frame_end_o = en_i && (&cnt_q);
endmodule

// File: rtl/pmod_in.sv
// rtl/pmod_in.sv - I2S master receiver for the Pmod I2S2 line-in ADC
// PMOD_IN_PEAK_EN adds the peak level meter output.
module pmod_in
    import pmod_i2s_pkg::*;
#(
    parameter int CLK_PER_MCLK_LOG2 = 3,
    parameter int SAMPLE_W          = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                SDOUT,
    output logic                MCLK,
    output logic                LRCLK,
    output logic                SCLK,
    output logic [SAMPLE_W-1:0] left,
    output logic [SAMPLE_W-1:0] right,
    output logic                valid
`ifdef PMOD_IN_PEAK_EN
    ,
    output logic [SAMPLE_W-2:0] peak
`endif
);
    logic              sample;
    logic              frame_end;
    logic [SLOT_W-1:0] slot;
    i2s_ch_e           ch;

    logic                  sd_meta_q;
    logic                  sd_sync_q;
    logic [ADC_DATA_W-1:0] left_sr_q, left_sr_d;
    logic [ADC_DATA_W-1:0] right_sr_q, right_sr_d;
    logic [SAMPLE_W-1:0]   left_q, left_d;
    logic [SAMPLE_W-1:0]   right_q, right_d;
    logic                  valid_q, valid_d;

    pmod_i2s_clkgen #(
        .CLK_PER_MCLK_LOG2(CLK_PER_MCLK_LOG2)
    ) u_clkgen (
        .clk        (clk),
        .rst        (rst),
        .en_i       (en),
        .mclk_o     (MCLK),
        .sclk_o     (SCLK),
        .lrclk_o    (LRCLK),
        .slot_o     (slot),
        .ch_o       (ch),
        .sample_o   (sample),
        .frame_end_o(frame_end)
    );

    // Exactly ADC_DATA_W bits shift in per channel per frame, so no per-frame clear is needed.
    always_comb begin
        left_sr_d  = left_sr_q;
        right_sr_d = right_sr_q;
        if (!en) begin
            left_sr_d  = '0;
            right_sr_d = '0;
        end else if (sample && is_data_slot(slot)) begin
            if (ch == CH_LEFT) begin
                left_sr_d = {left_sr_q[ADC_DATA_W-2:0], sd_sync_q};
            end else begin
                right_sr_d = {right_sr_q[ADC_DATA_W-2:0], sd_sync_q};
            end
        end
    end

    always_comb begin
        left_d  = left_q;
        right_d = right_q;
        valid_d = frame_end;
        if (frame_end) begin
            left_d  = left_sr_q[ADC_DATA_W-1 -: SAMPLE_W];
            right_d = right_sr_q[ADC_DATA_W-1 -: SAMPLE_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sd_meta_q  <= 1'b0;
            sd_sync_q  <= 1'b0;
            left_sr_q  <= '0;
            right_sr_q <= '0;
            left_q     <= '0;
            right_q    <= '0;
            valid_q    <= 1'b0;
        end else begin
            sd_meta_q  <= SDOUT;
            sd_sync_q  <= sd_meta_q;
            left_sr_q  <= left_sr_d;
            right_sr_q <= right_sr_d;
            left_q     <= left_d;
            right_q    <= right_d;
            valid_q    <= valid_d;
        end
    end

    assign left  = left_q;
    assign right = right_q;
    assign valid = valid_q;

`ifdef PMOD_IN_PEAK_EN
    logic [SAMPLE_W-2:0] peak_q, peak_d;
    logic [SAMPLE_W-2:0] mag_l, mag_r, mag_max;

    // Most negative code has no positive twin; clamp it to full scale.
    function automatic logic [SAMPLE_W-2:0] abs_sat(input logic [SAMPLE_W-1:0] x);
        logic [SAMPLE_W-1:0] neg;
        neg = -x;
        if (!x[SAMPLE_W-1]) begin
            return x[SAMPLE_W-2:0];
        end else if (x[SAMPLE_W-2:0] == '0) begin
            return '1;
        end else begin
            return neg[SAMPLE_W-2:0];
        end
    endfunction

    always_comb begin
        mag_l   = abs_sat(left_d);
        mag_r   = abs_sat(right_d);
        mag_max = (mag_l > mag_r) ? mag_l : mag_r;
        peak_d  = peak_q;
        if (frame_end) begin
            if (mag_max > peak_q) begin
                peak_d = mag_max;
            end else if (peak_q != '0) begin
                peak_d = peak_q - (SAMPLE_W-1)'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak = peak_q;
`endif
endmodule
